// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit between a CPU request/response port and a
// single-port data memory. It takes one request at a time, flags misaligned
// or illegal accesses without touching DMEM, and otherwise issues a one-cycle
// DMEM strobe. Load data is captured one cycle after the read strobe.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    CPU request handshake (ready only while idle)
//   req_we                 1 = store, 0 = load
//   req_byte_sel           00 byte, 01 half, 10 word, 11 illegal
//   req_sign               extension flag, passed through to DMEM
//   req_addr, req_wdata    byte address, store data
//   rsp_valid/rsp_ready    CPU response handshake
//   rsp_rdata, rsp_err     load data (0 for stores/errors), error flag
//   err_cnt                saturating count of completed error responses
//   dmem_rden, dmem_wen    DMEM strobes, high only in ISSUE
//   dmem_byte_sel, dmem_sign, dmem_addr, dmem_data_in   DMEM request fields
//   dmem_data_out          DMEM read data, valid the cycle after dmem_rden
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a request
// ISSUE | one DMEM strobe (read or write) is on the bus this cycle
// WAIT  | load: DMEM read data is valid, captured at the end of cycle
// RESP  | response held on rsp_* until the CPU takes it

module dmem_lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_byte_sel,
    input  logic        req_sign,
    input  logic [13:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] err_cnt,
    output logic        dmem_rden,
    output logic        dmem_wen,
    output logic [1:0]  dmem_byte_sel,
    output logic        dmem_sign,
    output logic [13:0] dmem_addr,
    output logic [31:0] dmem_data_in,
    input  logic [31:0] dmem_data_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    logic   we_q;
    logic   misaligned;

    always_comb begin
        misaligned = 1'b0;
        case (req_byte_sel)
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            2'b11:   misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

    // Decoded from the state register only; no combinational path from req_*.
    assign req_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            we_q          <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
            err_cnt       <= '0;
            dmem_rden     <= 1'b0;
            dmem_wen      <= 1'b0;
            dmem_byte_sel <= '0;
            dmem_sign     <= 1'b0;
            dmem_addr     <= '0;
            dmem_data_in  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (misaligned) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            // The DMEM field registers double as the captured request.
                            state         <= ISSUE;
                            we_q          <= req_we;
                            dmem_rden     <= ~req_we;
                            dmem_wen      <= req_we;
                            dmem_byte_sel <= req_byte_sel;
                            dmem_sign     <= req_sign;
                            dmem_addr     <= req_addr;
                            dmem_data_in  <= req_we ? req_wdata : 32'd0;
                        end
                    end
                end
                ISSUE: begin
                    dmem_rden     <= 1'b0;
                    dmem_wen      <= 1'b0;
                    dmem_byte_sel <= '0;
                    dmem_sign     <= 1'b0;
                    dmem_addr     <= '0;
                    dmem_data_in  <= '0;
                    if (we_q) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= dmem_data_out;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        if (rsp_err && (err_cnt != 16'hFFFF))
                            err_cnt <= err_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: a table of single transactions against a small
// DMEM model, plus hand-written reset-abort sequences.

module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_byte_sel = 2'b00;
    logic        req_sign = 1'b0;
    logic [13:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] err_cnt;
    logic        dmem_rden;
    logic        dmem_wen;
    logic [1:0]  dmem_byte_sel;
    logic        dmem_sign;
    logic [13:0] dmem_addr;
    logic [31:0] dmem_data_in;
    logic [31:0] dmem_data_out;

    always #5 clk = ~clk;

    dmem_lsu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_byte_sel  (req_byte_sel),
        .req_sign      (req_sign),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .err_cnt       (err_cnt),
        .dmem_rden     (dmem_rden),
        .dmem_wen      (dmem_wen),
        .dmem_byte_sel (dmem_byte_sel),
        .dmem_sign     (dmem_sign),
        .dmem_addr     (dmem_addr),
        .dmem_data_in  (dmem_data_in),
        .dmem_data_out (dmem_data_out)
    );

    // DMEM model: 16 words, byte lanes by addr[1:0]; read data is only valid
    // the cycle after a read strobe, a marker value otherwise.
    logic [31:0] mem [0:15];

    always @(posedge clk) begin
        if (dmem_wen) begin
            case (dmem_byte_sel)
                2'b00: mem[dmem_addr[5:2]][8*dmem_addr[1:0] +: 8] <= dmem_data_in[7:0];
                2'b01: mem[dmem_addr[5:2]][16*dmem_addr[1] +: 16] <= dmem_data_in[15:0];
                default: mem[dmem_addr[5:2]] <= dmem_data_in;
            endcase
        end
        if (dmem_rden) dmem_data_out <= mem[dmem_addr[5:2]];
        else           dmem_data_out <= 32'hBAD0_BAD0;
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_err_cnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        we;
        logic [1:0]  bsel;
        logic        sign;
        logic [13:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        logic [3:0]  hold;
    } vec_t;

    vec_t vecs [10];

    task automatic run_txn(input int id, input vec_t v);
        int lat;
        int n_strobe;
        int exp_lat;
        exp_lat  = v.err ? 1 : (v.we ? 2 : 3);
        n_strobe = 0;
        @(negedge clk);
        check($sformatf("v%0d req_ready idle", id), {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_we       = v.we;
        req_byte_sel = v.bsel;
        req_sign     = v.sign;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        rsp_ready    = 1'b0;
        @(posedge clk); #1;
        // Scramble inputs after accept: the registered request must be used.
        req_valid    = 1'b0;
        req_we       = ~v.we;
        req_byte_sel = ~v.bsel;
        req_sign     = ~v.sign;
        req_addr     = ~v.addr;
        req_wdata    = ~v.wdata;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            if (dmem_rden || dmem_wen) begin
                n_strobe++;
                check($sformatf("v%0d wen", id),  {31'd0, dmem_wen},  {31'd0, v.we});
                check($sformatf("v%0d rden", id), {31'd0, dmem_rden}, {31'd0, ~v.we});
                check($sformatf("v%0d dmem_addr", id), {18'd0, dmem_addr}, {18'd0, v.addr});
                check($sformatf("v%0d dmem_bsel", id), {30'd0, dmem_byte_sel}, {30'd0, v.bsel});
                check($sformatf("v%0d dmem_sign", id), {31'd0, dmem_sign}, {31'd0, v.sign});
                check($sformatf("v%0d dmem_data_in", id), dmem_data_in, v.we ? v.wdata : 32'd0);
            end
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("v%0d latency", id), lat, exp_lat);
        check($sformatf("v%0d strobes", id), n_strobe, v.err ? 0 : 1);
        check($sformatf("v%0d strobe in resp", id), {30'd0, dmem_rden, dmem_wen}, 32'd0);
        check($sformatf("v%0d rsp_err", id), {31'd0, rsp_err}, {31'd0, v.err});
        check($sformatf("v%0d rsp_rdata", id), rsp_rdata, v.rdata);
        check($sformatf("v%0d req_ready resp", id), {31'd0, req_ready}, 32'd0);
        for (int i = 0; i < int'(v.hold); i++) begin
            @(posedge clk); #1;
            check($sformatf("v%0d hold valid", id), {31'd0, rsp_valid}, 32'd1);
            check($sformatf("v%0d hold rdata", id), rsp_rdata, v.rdata);
            check($sformatf("v%0d hold ready", id), {31'd0, req_ready}, 32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        if (v.err) exp_err_cnt = exp_err_cnt + 16'd1;
        check($sformatf("v%0d valid after hs", id), {31'd0, rsp_valid}, 32'd0);
        check($sformatf("v%0d idle after hs", id), {31'd0, req_ready}, 32'd1);
        check($sformatf("v%0d err_cnt", id), {16'd0, err_cnt}, {16'd0, exp_err_cnt});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
        check({tag, " rsp_err"},   {31'd0, rsp_err}, 32'd0);
        check({tag, " err_cnt"},   {16'd0, err_cnt}, 32'd0);
        check({tag, " strobes"},   {30'd0, dmem_rden, dmem_wen}, 32'd0);
        check({tag, " dmem_fields"}, {dmem_data_in[31:17] | dmem_data_in[16:2],
                                      dmem_byte_sel, dmem_sign, dmem_addr | {12'd0, dmem_data_in[1:0]}},
              32'd0);
    endtask

    task automatic start_req(input logic we, input logic [13:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_byte_sel = 2'b10;
        req_sign     = 1'b0;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        mem[2] = 32'h1234_8765;

        //          we    bsel   sign  addr   wdata          err   rdata          hold
        vecs[0] = '{1'b1, 2'b10, 1'b0, 14'd0, 32'hDEADBEEF, 1'b0, 32'd0,         4'd0};
        vecs[1] = '{1'b0, 2'b10, 1'b0, 14'd0, 32'd0,        1'b0, 32'hDEADBEEF,  4'd5};
        vecs[2] = '{1'b0, 2'b01, 1'b1, 14'd8, 32'd0,        1'b0, 32'h1234_8765, 4'd0};
        vecs[3] = '{1'b1, 2'b10, 1'b0, 14'd1, 32'h5555AAAA, 1'b1, 32'd0,         4'd0};
        vecs[4] = '{1'b0, 2'b11, 1'b0, 14'd0, 32'd0,        1'b1, 32'd0,         4'd2};
        vecs[5] = '{1'b0, 2'b01, 1'b0, 14'd2, 32'd0,        1'b0, 32'hDEADBEEF,  4'd0};
        vecs[6] = '{1'b0, 2'b01, 1'b0, 14'd3, 32'd0,        1'b1, 32'd0,         4'd0};
        vecs[7] = '{1'b1, 2'b00, 1'b0, 14'd7, 32'h0000_00AA, 1'b0, 32'd0,        4'd0};
        vecs[8] = '{1'b0, 2'b10, 1'b0, 14'd4, 32'd0,        1'b0, 32'hAA00_0000, 4'd0};
        vecs[9] = '{1'b0, 2'b00, 1'b1, 14'd5, 32'd0,        1'b0, 32'hAA00_0000, 4'd0};

        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset req_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 10; i++) run_txn(i, vecs[i]);

        // Reset during WAIT of a load aborts it; no response after release.
        start_req(1'b0, 14'd0, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        exp_err_cnt = '0;
        check_all_zero("rst_wait");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("rst_wait no rsp", {31'd0, rsp_valid}, 32'd0);
        end
        run_txn(20, '{1'b1, 2'b10, 1'b0, 14'd12, 32'hCAFE_F00D, 1'b0, 32'd0, 4'd0});
        run_txn(21, '{1'b0, 2'b10, 1'b0, 14'd12, 32'd0, 1'b0, 32'hCAFE_F00D, 4'd0});

        // Reset during ISSUE drops the write strobe immediately.
        start_req(1'b1, 14'd16, 32'h0BAD_CAFE);
        check("rst_issue wen before", {31'd0, dmem_wen}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_issue");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_issue no rsp", {31'd0, rsp_valid}, 32'd0);
        check("rst_issue no write", mem[4], 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001: The block SHALL run from one clock and one reset; reset is asynchronous and active-low.
REQ-002: CLK  input  1  system clock; all state updates on rising edge.
REQ-003: RST_N  input  1  asynchronous active-low reset.
REQ-004: REQ_VALID  input  1  CPU memory request present.
REQ-005: REQ_READY  output  1  LSU can accept a request.
REQ-006: REQ_WE  input  1  1 = store, 0 = load.
REQ-007: REQ_BYTE_SEL  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008: REQ_SIGN  input  1  extension flag, forwarded unchanged to DMEM.
REQ-009: REQ_ADDR  input  14  byte address.
REQ-010: REQ_WDATA  input  32  store data.
REQ-011: RSP_VALID  output  1  response present.
REQ-012: RSP_READY  input  1  CPU accepts response.
REQ-013: RSP_RDATA  output  32  load data; 0 for stores and errors.
REQ-014: RSP_ERR  output  1  misaligned/illegal access, no DMEM access made.
REQ-015: ERR_CNT  output  16  saturating count of error responses.
REQ-016: DMEM_RDEN, DMEM_WEN  output  1 each  DMEM strobes.
REQ-017: DMEM_BYTE_SEL  output  2;  DMEM_SIGN  output  1;  DMEM_ADDR  output  14;  DMEM_DATA_IN  output  32: DMEM request fields.
REQ-018: DMEM_DATA_OUT  input  32  DMEM read data, valid the cycle after DMEM_RDEN is sampled high.

Function
REQ-019: The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-020: REQ_READY SHALL be 1 only in IDLE; a request is accepted on a rising edge where REQ_VALID && REQ_READY.
REQ-021: On accept, the block SHALL register WE, BYTE_SEL, SIGN, ADDR, WDATA; later REQ_* changes have no effect.
REQ-022: Misaligned SHALL mean: BYTE_SEL=10 with ADDR[1:0]!=0; BYTE_SEL=01 with ADDR[0]!=0; any BYTE_SEL=11.
REQ-023: Accepted misaligned request: IDLE->RESP directly, RSP_ERR=1, RSP_RDATA=0, no DMEM strobe ever asserted.
REQ-024: Accepted aligned request: IDLE->ISSUE; in ISSUE exactly one of DMEM_RDEN (load) or DMEM_WEN (store) SHALL be 1 for exactly one cycle, with DMEM_ADDR/BYTE_SEL/SIGN/DATA_IN from the registered request.
REQ-025: DMEM_DATA_IN SHALL be 0 for loads; strobes SHALL be 0 in every state except ISSUE.
REQ-026: Store: ISSUE->RESP; RSP_ERR=0, RSP_RDATA=0.
REQ-027: Load: ISSUE->WAIT; in WAIT, DMEM_DATA_OUT SHALL be captured into RSP_RDATA on the rising edge; WAIT->RESP.
REQ-028: Latency from accept edge to RSP_VALID high: error 1 cycle, store 2 cycles, load 3 cycles.
REQ-029: In RESP, RSP_VALID=1 and RSP_RDATA/RSP_ERR SHALL hold stable until RSP_READY; on RSP_VALID && RSP_READY -> IDLE.
REQ-030: A new request SHALL NOT be accepted in the same cycle a response completes (REQ_READY=0 in RESP).
REQ-031: ERR_CNT SHALL increment by 1 on each completed error response handshake, saturating at 16'hFFFF.
REQ-032: All outputs SHALL be driven from registers or the state register only (no combinational REQ_*->DMEM_* path).

Reset
REQ-033: RST_N low SHALL immediately force: state IDLE, REQ_READY=1 after release, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, ERR_CNT=0, all DMEM_* outputs 0.
REQ-034: Reset asserted mid-operation (ISSUE/WAIT/RESP) SHALL abort the transaction; no response is produced for it and strobes drop asynchronously.

Verification
REQ-035: Store word 32'hDEADBEEF at ADDR 0 -> DMEM_WEN=1 for one cycle with BYTE_SEL=10, ADDR=0; RSP_VALID 2 cycles after accept, RSP_ERR=0.
REQ-036: Load word ADDR 0 after REQ-035 (DMEM model) -> DMEM_RDEN one cycle; RSP_RDATA=32'hDEADBEEF 3 cycles after accept.
REQ-037: Load half ADDR 8 with SIGN=1 -> DMEM_BYTE_SEL=01, DMEM_SIGN=1, RSP_RDATA equals DMEM_DATA_OUT sampled in WAIT.
REQ-038: Store word ADDR 1 -> no DMEM strobe, RSP_ERR=1 after 1 cycle, ERR_CNT 0->1 on handshake; BYTE_SEL=11 at ADDR 0 likewise errors.
REQ-039: Hold RSP_READY=0 for 5 cycles in RESP -> RSP_VALID/RSP_RDATA stable, REQ_READY=0; release -> IDLE next cycle.
REQ-040: Assert RST_N=0 during WAIT of a load -> all outputs 0 immediately, no RSP_VALID after release; next store completes normally.
